// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module   : program_counter
// Brief    : picoMIPS program counter with hold, increment, absolute and
//            relative branch, all modulo 2^P_SIZE.
// Revision : 1.0 - initial release
// ============================================================================
module program_counter #(
  parameter int P_SIZE = 6
) (
  input  logic              clk,
  input  logic              nRst,
  output logic [P_SIZE-1:0] addressOut,
  input  logic [P_SIZE-1:0] branchAddress,
  input  logic              inc,
  input  logic              branchAbs,
  input  logic              branchRel
);

  localparam logic [P_SIZE-1:0] c_one = {{(P_SIZE-1){1'b0}}, 1'b1};

  logic [P_SIZE-1:0] r_pc;
  logic [P_SIZE-1:0] w_pc_next;

  // Priority order: absolute branch, relative branch, increment, hold.
  // Sums are P_SIZE wide, so the carry drops and negative offsets wrap backwards.
  always_comb begin
    w_pc_next = r_pc;
    if (branchAbs)
      w_pc_next = branchAddress;
    else if (branchRel)
      w_pc_next = r_pc + branchAddress;
    else if (inc)
      w_pc_next = r_pc + c_one;
  end

  always_ff @(posedge clk) begin
    if (nRst)
      r_pc <= '0;
    else
      r_pc <= w_pc_next;
  end

  assign addressOut = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_counter
// Brief    : Self-checking bench for program_counter against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_counter;

  localparam int P_SIZE = 6;
  localparam int c_span = 1 << P_SIZE;

  logic              clk;
  logic              nRst;
  logic [P_SIZE-1:0] addressOut;
  logic [P_SIZE-1:0] branchAddress;
  logic              inc;
  logic              branchAbs;
  logic              branchRel;

  int checks;
  int errors;
  int model_pc;

  program_counter #(.P_SIZE(P_SIZE)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .addressOut   (addressOut),
    .branchAddress(branchAddress),
    .inc          (inc),
    .branchAbs    (branchAbs),
    .branchRel    (branchRel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, advance the model by the stated rules,
  // then compare the registered output just after the edge.
  task automatic step(input logic rst, input logic abs, input logic rel,
                      input logic incr, input int addr, input string tag);
    @(negedge clk);
    nRst          = rst;
    branchAbs     = abs;
    branchRel     = rel;
    inc           = incr;
    branchAddress = addr[P_SIZE-1:0];
    @(posedge clk);
    if (rst)       model_pc = 0;
    else if (abs)  model_pc = addr % c_span;
    else if (rel)  model_pc = (model_pc + (addr % c_span)) % c_span;
    else if (incr) model_pc = (model_pc + 1) % c_span;
    #1;
    check(tag, int'(addressOut), model_pc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_pc = 0;
    nRst = 1'b0; branchAbs = 1'b0; branchRel = 1'b0; inc = 1'b0;
    branchAddress = '0;

    // Reset and hold
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, "reset");
    check("reset_const", int'(addressOut), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, "hold");
    check("hold_const", int'(addressOut), 0);

    // Full increment sweep ending in wrap to 0
    for (int i = 1; i <= c_span; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, $urandom_range(0, c_span - 1), "inc_sweep");
      check("inc_sweep_const", int'(addressOut), i % c_span);
    end

    step(1'b0, 1'b1, 1'b0, 1'b0, 5, "abs5");
    check("abs5_const", int'(addressOut), 5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8, "rel8");
    check("rel8_const", int'(addressOut), 13);
    step(1'b0, 1'b0, 1'b1, 1'b0, 63, "rel_minus1");
    check("rel_minus1_const", int'(addressOut), 12);
    step(1'b0, 1'b1, 1'b0, 1'b0, 60, "abs60");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8, "rel_wrap");
    check("rel_wrap_const", int'(addressOut), 4);

    // Priority resolution
    step(1'b0, 1'b1, 1'b0, 1'b0, 13, "abs13");
    step(1'b0, 1'b1, 1'b1, 1'b1, 20, "prio_abs");
    check("prio_abs_const", int'(addressOut), 20);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3, "prio_rel");
    check("prio_rel_const", int'(addressOut), 23);

    // Reset mid-run with inc and a branch asserted
    step(1'b0, 1'b1, 1'b0, 1'b0, 30, "abs30");
    step(1'b1, 1'b1, 1'b1, 1'b1, 17, "rst_override");
    check("rst_override_const", int'(addressOut), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, "post_rst_inc");
    check("post_rst_inc_const", int'(addressOut), 1);

    // Randomized mix with occasional resets
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, c_span - 1),
           "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_counter.md
# program_counter

Registered program counter for the picoMIPS core. Holds the current instruction address and updates it once per clock to hold, increment, branch to an absolute address, or branch by a relative offset. Its output drives the program memory address; branch requests and target/offset come from the decoder and branch logic.

## Interface

- One clock; reset is synchronous and active-high.

Parameters:
- P_SIZE, 6, address width in bits; program space is 2^P_SIZE words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- nRst  input  1  synchronous reset, active-high: when 1 at a rising edge, the address is cleared.
- addressOut  output  P_SIZE  current program address, driven directly from the PC register.
- branchAddress  input  P_SIZE  absolute target when branchAbs is asserted; offset when branchRel is asserted.
- inc  input  1  advance the address by 1.
- branchAbs  input  1  load branchAddress into the PC.
- branchRel  input  1  add branchAddress to the PC.

## Operation

- Single P_SIZE-bit register PC; addressOut = PC at all times, with no combinational path from the inputs.
- Next-state priority, evaluated at each rising clk:
  1. nRst = 1 -> PC <= 0.
  2. branchAbs = 1 -> PC <= branchAddress.
  3. branchRel = 1 -> PC <= PC + branchAddress.
  4. inc = 1 -> PC <= PC + 1.
  5. Otherwise -> PC holds.
- Arithmetic is modulo 2^P_SIZE, with carry discarded:
  - Increment from 2^P_SIZE-1 wraps to 0.
  - Relative add overflow wraps.
  - The offset is added as a raw P_SIZE-bit value, so two's-complement encodings give backward branches (e.g. offset 2^P_SIZE-1 = -1).
- Simultaneous requests resolve strictly by the priority above; inc is ignored whenever either branch is asserted.
- branchAddress is don't-care when neither branch is asserted.

## Timing

- Latency: one cycle. Inputs sampled at rising edge N appear on addressOut after edge N; there is no same-cycle effect.
- Reset value of addressOut is 0, valid after the first rising edge with nRst = 1.
- Before the first reset, the value is undefined.
- Reset asserted mid-operation, including while inc or a branch is asserted, forces 0 at that edge. Reset overrides all other inputs.
- The cycle after reset deasserts, normal operation resumes from 0.
- Holding inc high produces one increment per cycle: sequence 0,1,...,2^P_SIZE-1,0.
- There are no handshakes or stall states; every cycle performs exactly one of the five actions.

## Test plan

- Reset and hold: apply nRst = 1 for one edge, then release with all controls 0 -> addressOut = 0 after reset and still 0 one cycle later.
- Increment and wrap (P_SIZE = 6): inc = 1 for 64 cycles from 0 -> addressOut reads 0,1,...,63 on successive cycles, then 0.
- Absolute branch: from 0, branchAbs = 1, branchAddress = 5 for one cycle -> addressOut = 5.
- Relative branch: from 5, branchRel = 1, branchAddress = 8 for one cycle -> 13. Then branchAddress = 63 (-1) -> 12. From 60, offset 8 -> 4 (wrap).
- Priority: from 13, set branchAbs = 1, branchRel = 1, inc = 1, branchAddress = 20 -> 20. Then branchRel = 1, inc = 1, branchAddress = 3 -> 23, not 24.
- Reset mid-run: while incrementing at 30 with inc = 1, pulse nRst = 1 for one edge -> 0. Next cycle, with inc still 1 -> 1.
